// File: rtl/kplic_gateway_ctrl.sv
// kplic_gateway_ctrl
// Per-source interrupt gateway sitting between raw peripheral lines and the
// KPLIC core. Each source owns a small FSM (IDLE/FWD/WAIT/SVC) that turns a
// level or rising-edge source into a single-cycle request pulse, holds the
// source off until the target claims and completes it, and buffers extra
// edges in a saturating counter so edges arriving during service are not lost.
module kplic_gateway_ctrl #(
    parameter int INT_NUM    = 32,
    parameter int INT_WIDTH  = 5,
    parameter int EDGE_CNT_W = 3
) (
    input  logic                 kplic_clk,
    input  logic                 kplic_rst,
    input  logic [INT_NUM-1:0]   int_src,
    input  logic [INT_NUM-1:0]   int_type,
    input  logic [INT_NUM-1:0]   int_enable,
    input  logic                 int_claim,
    input  logic [INT_WIDTH-1:0] claim_id,
    input  logic                 int_complete,
    input  logic [INT_WIDTH-1:0] complete_id,
    output logic [INT_NUM-1:0]   valid_int_req,
    output logic [INT_NUM-1:0]   int_in_service,
    output logic [INT_NUM-1:0]   edge_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SVC  = 2'd3
    } gw_state_t;

    // Delayed copy of the source lines for edge detection. It keeps loading
    // during reset so a line already high at reset release is not an edge.
    logic [INT_NUM-1:0] src_d_reg;

    // Register the raw lines every cycle, reset included.
    always_ff @(posedge kplic_clk) begin
        src_d_reg <= int_src;
    end

    genvar gi;
    generate
        for (gi = 0; gi < INT_NUM; gi++) begin : g_src
            gw_state_t             state_reg;
            logic [EDGE_CNT_W-1:0] cnt_reg;
            logic                  ovf_reg;
            logic                  req_reg;
            logic                  svc_reg;

            logic rise;
            logic inc;
            logic go;
            logic dec;
            logic cnt_nz;
            logic cnt_max;
            logic claim_hit;
            logic complete_hit;

            assign rise    = int_src[gi] & ~src_d_reg[gi];
            // Edges are only buffered for enabled sources in edge mode.
            assign inc     = rise & int_enable[gi] & int_type[gi];
            assign cnt_nz  = |cnt_reg;
            assign cnt_max = &cnt_reg;
            // A fresh edge this cycle may forward directly, bypassing the counter.
            assign go      = (state_reg == ST_IDLE) && int_enable[gi] &&
                             (int_type[gi] ? (cnt_nz || inc) : int_src[gi]);
            assign dec     = go & int_type[gi];

            // IDs outside the source range never match any gi.
            assign claim_hit    = int_claim    && (claim_id    == INT_WIDTH'(gi));
            assign complete_hit = int_complete && (complete_id == INT_WIDTH'(gi));

            // Gateway FSM with registered request/in-service outputs, plus the edge counter.
            always_ff @(posedge kplic_clk) begin
                if (kplic_rst) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    ovf_reg   <= 1'b0;
                    req_reg   <= 1'b0;
                    svc_reg   <= 1'b0;
                end else begin
                    req_reg <= 1'b0;
                    case (state_reg)
                        ST_IDLE: begin
                            if (go) begin
                                state_reg <= ST_FWD;
                                req_reg   <= 1'b1;
                            end
                        end
                        ST_FWD: begin
                            state_reg <= ST_WAIT;
                        end
                        ST_WAIT: begin
                            if (claim_hit) begin
                                state_reg <= ST_SVC;
                                svc_reg   <= 1'b1;
                            end
                        end
                        ST_SVC: begin
                            if (complete_hit) begin
                                state_reg <= ST_IDLE;
                                svc_reg   <= 1'b0;
                            end
                        end
                        default: begin
                            state_reg <= ST_IDLE;
                            svc_reg   <= 1'b0;
                        end
                    endcase

                    // Level mode keeps the counter flushed; an edge consumed
                    // in the same cycle it arrives leaves the count untouched.
                    if (!int_type[gi]) begin
                        cnt_reg <= '0;
                    end else if (inc && !dec) begin
                        if (cnt_max) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + EDGE_CNT_W'(1);
                        end
                    end else if (dec && !inc) begin
                        cnt_reg <= cnt_reg - EDGE_CNT_W'(1);
                    end
                end
            end

            assign valid_int_req[gi]  = req_reg;
            assign int_in_service[gi] = svc_reg;
            assign edge_overflow[gi]  = ovf_reg;
        end
    endgenerate

endmodule
